// File: rtl/exe_mem_pipe_stage_if.sv
// EXE->MEM stage bus: EXE-side handshake/payload, MEM-side handshake/payload and the error flag.
// master = surrounding pipeline (drives EXE payload, mem_ready); slave = the stage itself.
interface exe_mem_pipe_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              exe_valid;
  logic              exe_ready;
  logic [DATA_W-1:0] exe_sw_o;
  logic [DATA_W-1:0] exe_write_o;
  logic [DATA_W-1:0] exe_alu_result;
  logic              exe_lwsrc;
  logic              exe_movsrc;
  logic              exe_DM_read;
  logic              exe_DM_write;

  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_sw_o;
  logic [DATA_W-1:0] mem_write_o;
  logic [DATA_W-1:0] mem_alu_result;
  logic              mem_lwsrc;
  logic              mem_movsrc;
  logic              mem_DM_read;
  logic              mem_DM_write;

  logic              ctrl_err;

  modport master (
    output exe_valid, exe_sw_o, exe_write_o, exe_alu_result,
           exe_lwsrc, exe_movsrc, exe_DM_read, exe_DM_write, mem_ready,
    input  exe_ready, mem_valid, mem_sw_o, mem_write_o, mem_alu_result,
           mem_lwsrc, mem_movsrc, mem_DM_read, mem_DM_write, ctrl_err
  );

  modport slave (
    input  exe_valid, exe_sw_o, exe_write_o, exe_alu_result,
           exe_lwsrc, exe_movsrc, exe_DM_read, exe_DM_write, mem_ready,
    output exe_ready, mem_valid, mem_sw_o, mem_write_o, mem_alu_result,
           mem_lwsrc, mem_movsrc, mem_DM_read, mem_DM_write, ctrl_err
  );
endinterface

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline stage: valid/ready handshake, 2-entry skid buffer, sync flush, gated DM strobes.
// Optional macro EXE_MEM_STALL_CNT_EN adds a saturating stall_cnt output.
module exe_mem_pipe_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  exe_mem_pipe_stage_if.slave   bus
`ifdef EXE_MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] sw;
    logic [DATA_W-1:0] wr;
    logic [DATA_W-1:0] alu;
    logic              lwsrc;
    logic              movsrc;
    logic              dm_rd;
    logic              dm_wr;
  } entry_t;

  // Occupancy replaces separate main/skid valid bits; skid is only ever full when main is.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_BOTH  = 2'd2
  } occ_e;

  occ_e   occ_q, occ_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   err_q, err_d;

  entry_t in_e;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   consume;

  always_comb begin
    in_e        = '0;
    in_e.sw     = bus.exe_sw_o;
    in_e.wr     = bus.exe_write_o;
    in_e.alu    = bus.exe_alu_result;
    in_e.lwsrc  = bus.exe_lwsrc;
    in_e.movsrc = bus.exe_movsrc;
    in_e.dm_rd  = bus.exe_DM_read;
    in_e.dm_wr  = bus.exe_DM_write;
  end

  assign main_valid = (occ_q != OCC_EMPTY);
  assign skid_valid = (occ_q == OCC_BOTH);
  assign accept     = bus.exe_valid & ~skid_valid;
  assign consume    = main_valid & bus.mem_ready;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    err_d  = err_q | (accept & bus.exe_DM_read & bus.exe_DM_write);

    unique case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          main_d = in_e;
          occ_d  = OCC_MAIN;
        end
      end
      OCC_MAIN: begin
        if (consume) begin
          if (accept) begin
            main_d = in_e;
          end else begin
            occ_d = OCC_EMPTY;
          end
        end else if (accept) begin
          skid_d = in_e;
          occ_d  = OCC_BOTH;
        end
      end
      OCC_BOTH: begin
        if (consume) begin
          main_d = skid_q;
          occ_d  = OCC_MAIN;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase

    // Payload may still load during flush; only occupancy is killed.
    if (flush) begin
      occ_d = OCC_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      err_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      err_q  <= err_d;
    end
  end

  assign bus.exe_ready      = ~skid_valid;
  assign bus.mem_valid      = main_valid;
  assign bus.mem_sw_o       = main_q.sw;
  assign bus.mem_write_o    = main_q.wr;
  assign bus.mem_alu_result = main_q.alu;
  assign bus.mem_lwsrc      = main_q.lwsrc;
  assign bus.mem_movsrc     = main_q.movsrc;
  assign bus.mem_DM_read    = main_q.dm_rd & main_valid;
  assign bus.mem_DM_write   = main_q.dm_wr & main_valid;
  assign bus.ctrl_err       = err_q;

`ifdef EXE_MEM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !bus.mem_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/exe_mem_pipe_stage.md
Name: exe_mem_pipe_stage

Overview:
- Parametrised EXE->MEM pipeline stage. Successor to the fixed-width, always-advancing EXE/MEM register.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput under backpressure), a synchronous flush and bubble-safe data-memory strobes.
- Sits between the ALU/EXE stage and the data-memory/MEM stage of the pipeline.

Parameters:
- DATA_W, 32, width of store data, write-back data and ALU result fields.
- CNT_W, 16, width of the stall counter (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries (branch/exception redirect).
- exe_valid  input  1  EXE presents a valid entry.
- exe_ready  output  1  stage can accept an entry this cycle.
- exe_sw_o  input  DATA_W  store data.
- exe_write_o  input  DATA_W  register write-back data.
- exe_alu_result  input  DATA_W  ALU result / memory address.
- exe_lwsrc  input  1  write-back source select (0 = ALU, 1 = load).
- exe_movsrc  input  1  move source select (0 = ALU).
- exe_DM_read  input  1  data-memory read request.
- exe_DM_write  input  1  data-memory write request.
- mem_valid  output  1  MEM-side entry valid.
- mem_ready  input  1  MEM consumes the entry this cycle.
- mem_sw_o, mem_write_o, mem_alu_result  output  DATA_W  registered payload.
- mem_lwsrc, mem_movsrc  output  1  registered selects.
- mem_DM_read, mem_DM_write  output  1  strobes, gated by mem_valid.
- ctrl_err  output  1  sticky flag: an accepted entry had both DM_read and DM_write set.

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-low. While rst = 0, all state clears immediately:
  - main and skid valid bits = 0;
  - all payload registers = 0 (lwsrc = ALU source, movsrc = ALU source, DM read/write disabled);
  - ctrl_err = 0.
- Reset asserted mid-transfer drops all held entries; no partial state survives.
- Storage: main register (drives mem_*) and skid register, each holding a valid bit plus the full payload.
- exe_ready = ~skid_valid. It is registered, so there is no combinational path from mem_ready.
- Accept = exe_valid & exe_ready. Consume = mem_valid & mem_ready. mem_valid = main_valid.
- Latency: an entry accepted in cycle N appears on mem_* in cycle N+1 if the main register is free or being consumed.
- Per-cycle rules (flush low):
  - Main empty, or main consumed with skid empty: an accepted entry loads main; otherwise main_valid <= 0 after consume.
  - Main consumed with skid full: skid moves into main, skid_valid <= 0. exe_ready was 0, so no accept occurs.
  - Main full and not consumed with an accept: the entry loads skid, skid_valid <= 1, and exe_ready drops next cycle.
  - Main full, not consumed, no accept: hold all state.
- Order is preserved: the skid entry always precedes any newer input.
- Sustained throughput is 1 entry/cycle while mem_ready = 1.
- Flush (synchronous): main_valid <= 0 and skid_valid <= 0. An input accepted in the same cycle is discarded. A consume in the same cycle completes normally. Payload registers may keep stale values.
- mem_DM_read = main_DM_read & main_valid; mem_DM_write = main_DM_write & main_valid. Bubbles never strobe memory.
- ctrl_err sets on an accept with exe_DM_read = exe_DM_write = 1. It clears only on reset. The entry is still passed through unmodified.
- Payload widths are exactly DATA_W; there is no arithmetic on payload.

Optional Feature:
- Macro: EXE_MEM_STALL_CNT_EN.
- With the macro: extra output stall_cnt [CNT_W] (output). It increments each cycle where mem_valid = 1 and mem_ready = 0, and saturates at all-ones (no wrap). It clears on reset only; flush does not clear it.
- Without the macro: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst = 0 mid-stream with both entries full -> mem_valid = 0, exe_ready = 1, all mem_* = 0 and ctrl_err = 0 immediately (before the next clk edge).
- Streaming: mem_ready = 1, 8 back-to-back entries with alu_result 0x10..0x17 -> mem_alu_result 0x10..0x17 on consecutive cycles, 1-cycle latency, exe_ready stays 1.
- Backpressure: mem_ready = 0 while entries A and B arrive ->
  - A held on mem_*, B in skid, exe_ready = 0 from the next cycle;
  - mem_ready = 1 -> A then B in order, exe_ready returns to 1.
- Flush: entries A (main) and B (skid) held; assert flush together with exe_valid for C -> next cycle mem_valid = 0, exe_ready = 1, and C never appears.
- Bubble gating: accepted entry with DM_write = 1, then exe_valid = 0 -> mem_DM_write = 1 for one consumed cycle, then 0.
- Error and counter: accept an entry with DM_read = DM_write = 1 -> ctrl_err = 1 and stays 1 after flush. With EXE_MEM_STALL_CNT_EN and CNT_W = 4, hold mem_ready = 0 with mem_valid = 1 for 20 cycles -> stall_cnt = 15 (saturated).
